// File: rtl/div_quotient_if.sv
// Handshake bundle between the reciprocal chain, the numerator source and the
// quotient consumer of div_quotient.
interface div_quotient_if #(
    parameter int PRECISION = 18
);
    logic                 req_vld;
    logic [PRECISION-1:0] req_n;
    logic                 recip_vld;
    logic [PRECISION-1:0] recip_r;
    logic                 out_vld;
    logic [PRECISION-1:0] out_q;
    logic                 out_ovf;
    logic                 full;
    logic                 err;

    modport master (
        output req_vld, req_n, recip_vld, recip_r,
        input  out_vld, out_q, out_ovf, full, err
    );

    modport slave (
        input  req_vld, req_n, recip_vld, recip_r,
        output out_vld, out_q, out_ovf, full, err
    );
endinterface

// File: rtl/div_quotient.sv
// Final quotient stage of a Newton-Raphson divider: aligns each numerator with
// its reciprocal, then multiplies, rounds and saturates in a 3-stage pipeline.
module div_quotient #(
    parameter int INTEGER   = 10,
    parameter int DECIMAL   = 7,
    parameter int PRECISION = 1 + INTEGER + DECIMAL,
    parameter int DEPTH     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    div_quotient_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2 * PRECISION;

    localparam logic [AW-1:0]        PTR_ONE   = AW'(1'b1);
    localparam logic [AW:0]          CNT_ONE   = (AW + 1)'(1'b1);
    localparam logic [AW:0]          CNT_ZERO  = (AW + 1)'(1'b0);
    localparam logic [AW:0]          FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [PRECISION-1:0] PREC_ONE  = PRECISION'(1'b1);
    localparam logic [PRECISION-1:0] PREC_ZERO = PRECISION'(1'b0);
    localparam logic [PRECISION-1:0] MAX_POS   = {1'b0, {(PRECISION-1){1'b1}}};
    localparam logic [PW-1:0]        HALF_LSB  = PW'(1'b1) << (DECIMAL - 1);

    // The most negative input maps to 2^(PRECISION-1), which still fits unsigned.
    function automatic logic [PRECISION-1:0] magnitude(input logic [PRECISION-1:0] v);
        logic [PRECISION-1:0] m;
        if (v[PRECISION-1]) begin
            m = ~v + PREC_ONE;
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic [PRECISION-1:0] mem_r [DEPTH];
    logic [AW-1:0]        wr_ptr_r;
    logic [AW-1:0]        rd_ptr_r;
    logic [AW:0]          count_r;
    logic [AW:0]          count_nxt_s;
    logic                 full_r;
    logic                 empty_r;
    logic                 err_r;

    logic                 pop_s;
    logic                 push_s;
    logic                 err_set_s;
    logic [PRECISION-1:0] head_s;

    logic                 s1_vld_r;
    logic [PRECISION-1:0] s1_mag_n_r;
    logic [PRECISION-1:0] s1_mag_d_r;
    logic                 s1_sign_r;
    logic                 s2_vld_r;
    logic [PW-1:0]        s2_mag_r;
    logic                 s2_sign_r;
    logic                 out_vld_r;
    logic [PRECISION-1:0] out_q_r;
    logic                 out_ovf_r;

    logic [PW-1:0]        prod_s;
    logic [PW-1:0]        rnd_s;
    logic                 sat_s;
    logic [PRECISION-1:0] mag3_s;
    logic [PRECISION-1:0] q3_s;

    // A full buffer still accepts a push when a pop frees a slot the same cycle;
    // an empty buffer never bypasses a same-cycle push to the reciprocal.
    assign pop_s     = bus.recip_vld & ~empty_r;
    assign push_s    = bus.req_vld & (~full_r | pop_s);
    assign err_set_s = (bus.recip_vld & empty_r) | (bus.req_vld & full_r & ~pop_s);
    assign head_s    = mem_r[rd_ptr_r];

    // Next occupancy, used to register exact full/empty flags.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Numerator storage; only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.req_n;
        end
    end

    // Buffer pointers, occupancy flags and the sticky protocol error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == FULL_CNT);
            empty_r <= (count_nxt_s == CNT_ZERO);
            if (err_set_s) begin
                err_r <= 1'b1;
            end
        end
    end

    // Adding half an LSB to the magnitude rounds half away from zero once the sign is reapplied.
    assign prod_s = {{PRECISION{1'b0}}, s1_mag_n_r} * {{PRECISION{1'b0}}, s1_mag_d_r};
    assign rnd_s  = (prod_s + HALF_LSB) >> DECIMAL;

    // Saturate the magnitude symmetrically, then restore the sign.
    always_comb begin
        sat_s  = (s2_mag_r > {{PRECISION{1'b0}}, MAX_POS});
        mag3_s = PREC_ZERO;
        q3_s   = PREC_ZERO;
        if (sat_s) begin
            mag3_s = MAX_POS;
        end else begin
            mag3_s = s2_mag_r[PRECISION-1:0];
        end
        if (s2_sign_r) begin
            q3_s = ~mag3_s + PREC_ONE;
        end else begin
            q3_s = mag3_s;
        end
    end

    // Three pipeline stages: magnitudes/sign, rounded product, saturated result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_r   <= 1'b0;
            s1_mag_n_r <= PREC_ZERO;
            s1_mag_d_r <= PREC_ZERO;
            s1_sign_r  <= 1'b0;
            s2_vld_r   <= 1'b0;
            s2_mag_r   <= {PW{1'b0}};
            s2_sign_r  <= 1'b0;
            out_vld_r  <= 1'b0;
            out_q_r    <= PREC_ZERO;
            out_ovf_r  <= 1'b0;
        end else begin
            s1_vld_r <= pop_s;
            if (pop_s) begin
                s1_mag_n_r <= magnitude(head_s);
                s1_mag_d_r <= magnitude(bus.recip_r);
                s1_sign_r  <= head_s[PRECISION-1] ^ bus.recip_r[PRECISION-1];
            end
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                s2_mag_r  <= rnd_s;
                s2_sign_r <= s1_sign_r;
            end
            out_vld_r <= s2_vld_r;
            if (s2_vld_r) begin
                out_q_r   <= q3_s;
                out_ovf_r <= sat_s;
            end
        end
    end

    assign bus.out_vld = out_vld_r;
    assign bus.out_q   = out_q_r;
    assign bus.out_ovf = out_ovf_r;
    assign bus.full    = full_r;
    assign bus.err     = err_r;
endmodule

// File: tb/tb_div_quotient.sv
// Directed and random stimulus for div_quotient with a queue-based scoreboard.
module tb_div_quotient;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    div_quotient_if #(.PRECISION(18)) bus();

    div_quotient #(.INTEGER(10), .DECIMAL(7), .DEPTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [17:0] q;
        logic        ovf;
    } exp_t;

    exp_t        eq[$];
    logic [17:0] mq[$];
    logic [17:0] outs_q[$];
    logic        outs_ovf[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic        err_m    = 1'b0;
    logic [17:0] last_q   = 18'h0;
    logic        last_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed product, round half away from zero, symmetric saturation.
    task automatic model(input logic [17:0] n, input logic [17:0] r,
                         output logic [17:0] q, output logic ovf);
        longint p;
        longint m;
        p = longint'($signed(n)) * longint'($signed(r));
        if (p >= 0) m = (p + 64) / 128;
        else        m = -((-p + 64) / 128);
        ovf = 1'b0;
        if (m > 131071) begin
            m = 131071;
            ovf = 1'b1;
        end else if (m < -131071) begin
            m = -131071;
            ovf = 1'b1;
        end
        q = m[17:0];
    endtask

    task automatic tick();
        bit          pop_ok;
        bit          push_ok;
        logic [17:0] n;
        logic [17:0] q;
        logic        o;
        bit          exp_vld;
        pop_ok = bus.recip_vld && (mq.size() != 0);
        if (bus.recip_vld && mq.size() == 0) err_m = 1'b1;
        if (bus.req_vld && mq.size() == 8 && !pop_ok) err_m = 1'b1;
        push_ok = bus.req_vld && (mq.size() < 8 || pop_ok);
        if (pop_ok) begin
            n = mq.pop_front();
            model(n, bus.recip_r, q, o);
            eq.push_back('{due: cyc + 3, q: q, ovf: o});
        end
        if (push_ok) mq.push_back(bus.req_n);
        @(posedge clk);
        cyc++;
        #1;
        exp_vld = (eq.size() != 0) && (eq[0].due == cyc);
        chk("out_vld", {31'b0, bus.out_vld}, {31'b0, exp_vld});
        if (exp_vld) begin
            exp_t e;
            e = eq.pop_front();
            chk("out_q", {14'b0, bus.out_q}, {14'b0, e.q});
            chk("out_ovf", {31'b0, bus.out_ovf}, {31'b0, e.ovf});
            last_q   = e.q;
            last_ovf = e.ovf;
        end else begin
            chk("out_q_hold", {14'b0, bus.out_q}, {14'b0, last_q});
            chk("out_ovf_hold", {31'b0, bus.out_ovf}, {31'b0, last_ovf});
        end
        if (bus.out_vld) begin
            outs_q.push_back(bus.out_q);
            outs_ovf.push_back(bus.out_ovf);
        end
        chk("full", {31'b0, bus.full}, {31'b0, mq.size() == 8});
        chk("err", {31'b0, bus.err}, {31'b0, err_m});
    endtask

    task automatic drv(input logic rv, input logic [17:0] n, input logic cv, input logic [17:0] r);
        bus.req_vld   = rv;
        bus.req_n     = n;
        bus.recip_vld = cv;
        bus.recip_r   = r;
        tick();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_vld"}, {31'b0, bus.out_vld}, 32'd0);
        chk({tag, "_out_q"}, {14'b0, bus.out_q}, 32'd0);
        chk({tag, "_out_ovf"}, {31'b0, bus.out_ovf}, 32'd0);
        chk({tag, "_full"}, {31'b0, bus.full}, 32'd0);
        chk({tag, "_err"}, {31'b0, bus.err}, 32'd0);
    endtask

    logic [17:0] vn  [6] = '{18'h00180, 18'h3FF00, 18'h00001, 18'h3FFFF, 18'h1F400, 18'h20C00};
    logic [17:0] vr  [6] = '{18'h00040, 18'h00020, 18'h00040, 18'h00040, 18'h00100, 18'h00100};
    logic [17:0] vq  [6] = '{18'h000C0, 18'h3FFC0, 18'h00001, 18'h3FFFF, 18'h1FFFF, 18'h20001};
    logic        vo  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        bus.req_vld   = 1'b0;
        bus.req_n     = 18'h0;
        bus.recip_vld = 1'b0;
        bus.recip_r   = 18'h0;

        // Reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #2 chk_reset_state("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv(1'b0, 18'h0, 1'b0, 18'h0);

        // Spec vectors: fill, then back-to-back reciprocals.
        for (int i = 0; i < 6; i++) drv(1'b1, vn[i], 1'b0, 18'h0);
        for (int i = 0; i < 6; i++) drv(1'b0, 18'h0, 1'b1, vr[i]);
        for (int i = 0; i < 4; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);
        chk("vec_count", outs_q.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < outs_q.size()) begin
                chk($sformatf("vec%0d_q", i), {14'b0, outs_q[i]}, {14'b0, vq[i]});
                chk($sformatf("vec%0d_ovf", i), {31'b0, outs_ovf[i]}, {31'b0, vo[i]});
            end
        end

        // Ordering and full: 8 pushes, dropped 9th, 8 pops of 1.0.
        outs_q.delete();
        outs_ovf.delete();
        for (int i = 1; i <= 8; i++) drv(1'b1, 18'(i), 1'b0, 18'h0);
        chk("full_at_8", {31'b0, bus.full}, 32'd1);
        drv(1'b1, 18'd9, 1'b0, 18'h0);
        chk("err_on_overflow", {31'b0, bus.err}, 32'd1);
        for (int i = 0; i < 8; i++) drv(1'b0, 18'h0, 1'b1, 18'h00080);
        for (int i = 0; i < 4; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);
        chk("order_count", outs_q.size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < outs_q.size()) chk($sformatf("order%0d", i), {14'b0, outs_q[i]}, i + 1);
        end

        // Push into a full buffer together with a pop: accepted, stays full.
        for (int i = 11; i <= 18; i++) drv(1'b1, 18'(i), 1'b0, 18'h0);
        drv(1'b1, 18'd19, 1'b1, 18'h00080);
        chk("full_push_pop", {31'b0, bus.full}, 32'd1);
        for (int i = 0; i < 8; i++) drv(1'b0, 18'h0, 1'b1, 18'h00080);
        for (int i = 0; i < 4; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);

        // Reset with three results in flight.
        for (int i = 0; i < 3; i++) drv(1'b1, 18'h00100, 1'b0, 18'h0);
        for (int i = 0; i < 3; i++) drv(1'b0, 18'h0, 1'b1, 18'h00080);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("rst_mid");
        mq.delete();
        eq.delete();
        err_m    = 1'b0;
        last_q   = 18'h0;
        last_ovf = 1'b0;
        @(posedge clk);
        cyc++;
        #1 chk_reset_state("rst_held");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);

        // Pop on empty, then same-cycle push and pop on empty (push kept).
        drv(1'b0, 18'h0, 1'b1, 18'h00040);
        chk("err_empty_pop", {31'b0, bus.err}, 32'd1);
        for (int i = 0; i < 4; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);
        drv(1'b1, 18'h00180, 1'b1, 18'h00040);
        drv(1'b0, 18'h0, 1'b1, 18'h00100);
        for (int i = 0; i < 4; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);
        chk("bypass_result", {14'b0, last_q}, 32'h00300);

        // Random traffic against the reference model.
        for (int i = 0; i < 60; i++) begin
            drv(1'($urandom_range(0, 1)), 18'($urandom), 1'($urandom_range(0, 1)), 18'($urandom));
        end
        for (int i = 0; i < 12; i++) drv(1'b0, 18'h0, mq.size() != 0, 18'($urandom));
        for (int i = 0; i < 4; i++) drv(1'b0, 18'h0, 1'b0, 18'h0);
        chk("drained", eq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/div_quotient.md
DIV_QUOTIENT -- requirements
Module: div_quotient

Interface
REQ-001 The block SHALL have parameters INTEGER (default 10, integer bits), DECIMAL (default 7, fraction bits) and PRECISION (default 1+INTEGER+DECIMAL, total signed width).
REQ-002 The block SHALL have parameter DEPTH (default 8, power of two >= 2), the numerator alignment buffer entries.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_vld, input, 1 bit: numerator push, asserted in the same cycle its divisor enters the reciprocal chain.
REQ-006 The block SHALL have port req_n, input, PRECISION bits: numerator, two's complement fixed point, DECIMAL fraction bits.
REQ-007 The block SHALL have port recip_vld, input, 1 bit: reciprocal valid from the Newton-Raphson chain.
REQ-008 The block SHALL have port recip_r, input, PRECISION bits: reciprocal 1/d, same format.
REQ-009 The block SHALL have port out_vld, output, 1 bit: quotient valid, single-cycle pulse per result.
REQ-010 The block SHALL have port out_q, output, PRECISION bits: quotient n*(1/d), same format.
REQ-011 The block SHALL have port out_ovf, output, 1 bit: out_q saturated; meaningful only with out_vld.
REQ-012 The block SHALL have port full, output, 1 bit: alignment buffer holds DEPTH entries.
REQ-013 The block SHALL have port err, output, 1 bit: sticky protocol error flag.

Function
REQ-014 Alignment buffer: FIFO of DEPTH numerators; push on req_vld, pop on recip_vld; strict in-order pairing of the k-th numerator with the k-th reciprocal.
REQ-015 Push with full=1 and no same-cycle pop: numerator dropped, err set; with a same-cycle pop, the push SHALL be accepted and the count unchanged.
REQ-016 recip_vld with the buffer empty: no bypass, even with a same-cycle push; reciprocal discarded, err set, no out_vld; any same-cycle push still stored.
REQ-017 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be registered and exact at every occupancy 0..DEPTH.
REQ-018 Stage 1 (cycle after pop): register |n| and |r| as PRECISION-bit unsigned magnitudes (most negative input maps to 2^(PRECISION-1)), and sign = sign(n) XOR sign(r).
REQ-019 Stage 2: unsigned product of magnitudes, 2*PRECISION bits; add 2^(DECIMAL-1), shift right by DECIMAL (round half away from zero in signed terms).
REQ-020 Stage 3: if the rounded magnitude exceeds 2^(PRECISION-1)-1, magnitude SHALL clamp to 2^(PRECISION-1)-1 and out_ovf=1; then negate if sign=1; a zero result SHALL be output as 0, never negative zero.
REQ-021 Latency: recip_vld in cycle t (buffer non-empty) -> out_vld in cycle t+3; full throughput, one result per cycle, no backpressure.
REQ-022 out_q and out_ovf SHALL hold their last value while out_vld=0.
REQ-023 err SHALL remain 1 until rst_n is asserted.

Reset
REQ-024 While rst_n=0: buffer empty, full=0, err=0, all pipeline valids 0, out_vld=0, out_q=0, out_ovf=0, effective immediately without clk.
REQ-025 Reset mid-operation SHALL discard all buffered numerators and in-flight results; no out_vld SHALL appear after deassertion until a new push/pop pair.

Verification (PRECISION=18, DECIMAL=7, DEPTH=8)
REQ-026 Basic: push n=0x00180 (3.0), recip r=0x00040 (0.5) at t -> out_vld at t+3, out_q=0x000C0 (1.5), out_ovf=0.
REQ-027 Sign/rounding: n=0x3FF00 (-2.0), r=0x00020 -> out_q=0x3FFC0 (-0.5); n=0x00001, r=0x00040 -> out_q=0x00001 (half rounds up); n=0x3FFFF, r=0x00040 -> out_q=0x3FFFF.
REQ-028 Saturation: n=0x1F400 (1000.0), r=0x00100 (2.0) -> out_q=0x1FFFF, out_ovf=1; with n negated -> out_q=0x20001, out_ovf=1.
REQ-029 Ordering/full: push 8 numerators 1..8 -> full=1; 9th push -> err=1, dropped; 8 back-to-back recips r=0x00080 -> out_q 1..8 on 8 consecutive cycles; full=0 after first pop.
REQ-030 Empty pop and reset: recip_vld on empty buffer -> err=1, no out_vld; rst_n low for one cycle with 3 in flight -> err=0, out_vld=0, no further results.
